// File: rtl/adc_align_ctrl.sv
// Frame-word alignment controller: slips the deserializers until the FCLK word matches FrmPattern.
// Optional lock-loss monitor in LOCKED is enabled by defining ADC_ALIGN_LOSS_MON_EN.
module adc_align_ctrl #(
  parameter int          AdcBits      = 14,
  parameter logic [15:0] FrmPattern   = 16'b0011111110000000,
  parameter int          SettleCycles = 4,
  parameter int          LockCount    = 16,
  parameter int          MaxSlips     = 16,
  parameter int          LossCount    = 4
) (
  input  logic        FrmClkDiv,
  input  logic        FrmRstn,
  input  logic        BitClkDone,
  input  logic        AlignStart,
  input  logic [15:0] FrmWord,
  output logic        FrmBitslip,
  output logic        FrmAlignDone,
  output logic        AlignErr,
  output logic [4:0]  SlipCnt,
  output logic [2:0]  AlignState
);

  typedef enum logic [2:0] {
    ST_WAIT_CLK = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_CHECK    = 3'd2,
    ST_SLIP     = 3'd3,
    ST_LOCKED   = 3'd4,
    ST_FAIL     = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_settle_cnt;
  logic [3:0] w_settle_nxt;
  logic [7:0] r_match_cnt;
  logic [7:0] w_match_nxt;
  logic [4:0] r_slip_cnt;
  logic [4:0] w_slip_nxt;
  logic       r_bitslip;
  logic       r_done;
  logic       r_err;
  logic       w_match;
`ifdef ADC_ALIGN_LOSS_MON_EN
  logic [3:0] r_loss_cnt;
  logic [3:0] w_loss_nxt;
`endif

  assign w_match = (FrmWord[AdcBits-1:0] == FrmPattern[AdcBits-1:0]);

  // Next-state and counter update; clock loss outranks restart, restart outranks the FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle_cnt;
    w_match_nxt  = r_match_cnt;
    w_slip_nxt   = r_slip_cnt;
`ifdef ADC_ALIGN_LOSS_MON_EN
    w_loss_nxt   = r_loss_cnt;
`endif
    if (!BitClkDone) begin
      w_state_nxt  = ST_WAIT_CLK;
      w_settle_nxt = 4'd0;
      w_match_nxt  = 8'd0;
      w_slip_nxt   = 5'd0;
`ifdef ADC_ALIGN_LOSS_MON_EN
      w_loss_nxt   = 4'd0;
`endif
    end else if (AlignStart && (r_state != ST_WAIT_CLK)) begin
      w_state_nxt  = ST_SETTLE;
      w_settle_nxt = 4'd0;
      w_match_nxt  = 8'd0;
      w_slip_nxt   = 5'd0;
`ifdef ADC_ALIGN_LOSS_MON_EN
      w_loss_nxt   = 4'd0;
`endif
    end else begin
      case (r_state)
        ST_WAIT_CLK: begin
          w_state_nxt  = ST_SETTLE;
          w_settle_nxt = 4'd0;
          w_match_nxt  = 8'd0;
        end
        ST_SETTLE: begin
          if (r_settle_cnt == 4'(SettleCycles - 1)) begin
            w_state_nxt  = ST_CHECK;
            w_settle_nxt = 4'd0;
          end else begin
            w_settle_nxt = r_settle_cnt + 4'd1;
          end
        end
        ST_CHECK: begin
          if (w_match) begin
            if (r_match_cnt == 8'(LockCount - 1)) begin
              w_state_nxt = ST_LOCKED;
              w_match_nxt = 8'd0;
`ifdef ADC_ALIGN_LOSS_MON_EN
              w_loss_nxt  = 4'd0;
`endif
            end else begin
              w_match_nxt = r_match_cnt + 8'd1;
            end
          end else begin
            w_match_nxt = 8'd0;
            if (r_slip_cnt == 5'(MaxSlips)) begin
              w_state_nxt = ST_FAIL;
            end else begin
              w_state_nxt = ST_SLIP;
              w_slip_nxt  = r_slip_cnt + 5'd1;
            end
          end
        end
        ST_SLIP: begin
          w_state_nxt  = ST_SETTLE;
          w_settle_nxt = 4'd0;
        end
        ST_LOCKED: begin
`ifdef ADC_ALIGN_LOSS_MON_EN
          if (w_match) begin
            w_loss_nxt = 4'd0;
          end else if (r_loss_cnt == 4'(LossCount - 1)) begin
            w_state_nxt  = ST_SETTLE;
            w_settle_nxt = 4'd0;
            w_slip_nxt   = 5'd0;
            w_loss_nxt   = 4'd0;
          end else begin
            w_loss_nxt = r_loss_cnt + 4'd1;
          end
`else
          w_state_nxt = ST_LOCKED;
`endif
        end
        ST_FAIL: begin
          w_state_nxt = ST_FAIL;
        end
        default: begin
          w_state_nxt = ST_WAIT_CLK;
        end
      endcase
    end
  end

  // State, counters and outputs; outputs are decoded from the next state so they align with it.
  always_ff @(posedge FrmClkDiv or negedge FrmRstn) begin
    if (!FrmRstn) begin
      r_state      <= ST_WAIT_CLK;
      r_settle_cnt <= 4'd0;
      r_match_cnt  <= 8'd0;
      r_slip_cnt   <= 5'd0;
      r_bitslip    <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
`ifdef ADC_ALIGN_LOSS_MON_EN
      r_loss_cnt   <= 4'd0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_match_cnt  <= w_match_nxt;
      r_slip_cnt   <= w_slip_nxt;
      r_bitslip    <= (w_state_nxt == ST_SLIP);
      r_done       <= (w_state_nxt == ST_LOCKED);
      r_err        <= (w_state_nxt == ST_FAIL);
`ifdef ADC_ALIGN_LOSS_MON_EN
      r_loss_cnt   <= w_loss_nxt;
`endif
    end
  end

  assign FrmBitslip   = r_bitslip;
  assign FrmAlignDone = r_done;
  assign AlignErr     = r_err;
  assign SlipCnt      = r_slip_cnt;
  assign AlignState   = r_state;

endmodule

// File: tb/tb_adc_align_ctrl.sv
// Directed self-checking bench for adc_align_ctrl with a rotating-word deserializer model.
module tb_adc_align_ctrl;

  localparam logic [15:0] PAT = 16'b0011111110000000;

  logic        FrmClkDiv = 1'b0;
  logic        FrmRstn = 1'b1;
  logic        BitClkDone = 1'b0;
  logic        AlignStart = 1'b0;
  logic [15:0] FrmWord = PAT;
  logic        FrmBitslip;
  logic        FrmAlignDone;
  logic        AlignErr;
  logic [4:0]  SlipCnt;
  logic [2:0]  AlignState;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int pulses = 0;
  int consec = 0;
  int offset = 0;
  bit track = 1'b0;
  bit prev_slip = 1'b0;
  int pc [0:3];

  adc_align_ctrl dut (
    .FrmClkDiv   (FrmClkDiv),
    .FrmRstn     (FrmRstn),
    .BitClkDone  (BitClkDone),
    .AlignStart  (AlignStart),
    .FrmWord     (FrmWord),
    .FrmBitslip  (FrmBitslip),
    .FrmAlignDone(FrmAlignDone),
    .AlignErr    (AlignErr),
    .SlipCnt     (SlipCnt),
    .AlignState  (AlignState)
  );

  always #5 FrmClkDiv = ~FrmClkDiv;

  function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
    logic [15:0] r;
    r = v;
    repeat (n) r = {r[14:0], r[15]};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample #1 after the edge and let the model respond to a bitslip pulse.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge FrmClkDiv);
      #1;
      cycle++;
      if (FrmBitslip === 1'b1) begin
        if (pulses < 4) pc[pulses] = cycle;
        pulses++;
        if (prev_slip) consec++;
        if (track) offset--;
      end
      prev_slip = (FrmBitslip === 1'b1);
      if (track) FrmWord = rotl(PAT, offset);
    end
  endtask

  initial begin
    // Reset state
    #2 FrmRstn = 1'b0;
    #1;
    chk("rst_state", 32'(AlignState), 32'd0);
    chk("rst_done", 32'(FrmAlignDone), 32'd0);
    chk("rst_err", 32'(AlignErr), 32'd0);
    chk("rst_bitslip", 32'(FrmBitslip), 32'd0);
    chk("rst_slipcnt", 32'(SlipCnt), 32'd0);
    #4 FrmRstn = 1'b1;
    tick(2);
    chk("wait_clk_hold", 32'(AlignState), 32'd0);

    // Clean lock: 21 cycles from BitClkDone rising
    pulses = 0;
    BitClkDone = 1'b1;
    tick(1);
    chk("settle_entry", 32'(AlignState), 32'd1);
    tick(4);
    chk("check_entry", 32'(AlignState), 32'd2);
    tick(15);
    chk("not_locked_at_20", 32'(FrmAlignDone), 32'd0);
    tick(1);
    chk("locked_at_21", 32'(FrmAlignDone), 32'd1);
    chk("locked_state", 32'(AlignState), 32'd4);
    chk("clean_slipcnt", 32'(SlipCnt), 32'd0);
    chk("clean_no_pulse", 32'(pulses), 32'd0);

    // Bad words while locked
    FrmWord = 16'h0000;
    tick(3);
    FrmWord = PAT;
    tick(1);
    chk("lock_3bad_1good_done", 32'(FrmAlignDone), 32'd1);
    chk("lock_3bad_1good_state", 32'(AlignState), 32'd4);
    FrmWord = 16'h0000;
    tick(4);
`ifdef ADC_ALIGN_LOSS_MON_EN
    chk("loss_done", 32'(FrmAlignDone), 32'd0);
    chk("loss_state", 32'(AlignState), 32'd1);
`else
    chk("noloss_done", 32'(FrmAlignDone), 32'd1);
    chk("noloss_state", 32'(AlignState), 32'd4);
`endif

    // Pattern rotated by 3: three slips, 6 cycles apart
    track = 1'b1;
    offset = 3;
    FrmWord = rotl(PAT, offset);
    pulses = 0;
    consec = 0;
    AlignStart = 1'b1;
    tick(1);
    AlignStart = 1'b0;
    chk("restart_state", 32'(AlignState), 32'd1);
    chk("restart_slipcnt", 32'(SlipCnt), 32'd0);
    for (int i = 0; i < 100 && FrmAlignDone !== 1'b1; i++) tick(1);
    chk("rot3_locked", 32'(FrmAlignDone), 32'd1);
    chk("rot3_pulses", 32'(pulses), 32'd3);
    chk("rot3_gap1", 32'(pc[1] - pc[0]), 32'd6);
    chk("rot3_gap2", 32'(pc[2] - pc[1]), 32'd6);
    chk("rot3_slipcnt", 32'(SlipCnt), 32'd3);
    chk("rot3_no_consec", 32'(consec), 32'd0);

    // Constant zero word: 16 slips then FAIL
    track = 1'b0;
    FrmWord = 16'h0000;
    pulses = 0;
    consec = 0;
    AlignStart = 1'b1;
    tick(1);
    AlignStart = 1'b0;
    for (int i = 0; i < 300 && AlignState !== 3'd5; i++) tick(1);
    chk("fail_state", 32'(AlignState), 32'd5);
    chk("fail_err", 32'(AlignErr), 32'd1);
    chk("fail_pulses", 32'(pulses), 32'd16);
    chk("fail_slipcnt", 32'(SlipCnt), 32'd16);
    chk("fail_done", 32'(FrmAlignDone), 32'd0);
    chk("fail_no_consec", 32'(consec), 32'd0);
    tick(3);
    chk("fail_sticky", 32'(AlignErr), 32'd1);
    AlignStart = 1'b1;
    tick(1);
    AlignStart = 1'b0;
    chk("fail_restart_err", 32'(AlignErr), 32'd0);
    chk("fail_restart_state", 32'(AlignState), 32'd1);

    // BitClkDone dropped during SLIP
    for (int i = 0; i < 30 && FrmBitslip !== 1'b1; i++) tick(1);
    chk("slip_reached", 32'(FrmBitslip), 32'd1);
    BitClkDone = 1'b0;
    tick(1);
    chk("clkloss_state", 32'(AlignState), 32'd0);
    chk("clkloss_bitslip", 32'(FrmBitslip), 32'd0);
    chk("clkloss_slipcnt", 32'(SlipCnt), 32'd0);
    chk("clkloss_done", 32'(FrmAlignDone), 32'd0);

    // Reset mid-SLIP ends the pulse at once
    BitClkDone = 1'b1;
    for (int i = 0; i < 30 && FrmBitslip !== 1'b1; i++) tick(1);
    chk("slip_reached2", 32'(FrmBitslip), 32'd1);
    FrmRstn = 1'b0;
    #1;
    chk("rstslip_bitslip", 32'(FrmBitslip), 32'd0);
    chk("rstslip_state", 32'(AlignState), 32'd0);
    chk("rstslip_slipcnt", 32'(SlipCnt), 32'd0);
    #1 FrmRstn = 1'b1;

    // Reset mid-CHECK
    FrmWord = PAT;
    tick(6);
    chk("midcheck_state", 32'(AlignState), 32'd2);
    FrmRstn = 1'b0;
    #1;
    chk("rstcheck_state", 32'(AlignState), 32'd0);
    chk("rstcheck_done", 32'(FrmAlignDone), 32'd0);
    chk("rstcheck_err", 32'(AlignErr), 32'd0);
    #1 FrmRstn = 1'b1;
    tick(1);
    chk("post_rst_settle", 32'(AlignState), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
